// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns clean level changes on i_data into a burst of glitches on o_data.
// Define BOUNCE_GEN_RANDOM_EN to draw glitch hold times from a 16-bit LFSR instead of a fixed period.
module bounce_generator #(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned GLITCH_MAX    = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  output logic o_data,
  output logic o_busy
);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t      state, state_next;
  logic        target, target_next;
  logic        data_next;
  logic [15:0] burst_cnt, burst_next;
  logic [7:0]  hold_cnt, hold_next;
  logic [7:0]  interval;
  logic        change;

  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("bounce_generator: LFSR_SEED must be nonzero");
  end
  if (GLITCH_MAX < 2 || GLITCH_MAX > 256 || (GLITCH_MAX & (GLITCH_MAX - 1)) != 0) begin : g_bad_glitch
    $error("bounce_generator: GLITCH_MAX must be a power of two in 2..256");
  end
  if (BOUNCE_CYCLES < 2 || BOUNCE_CYCLES > 65535) begin : g_bad_burst
    $error("bounce_generator: BOUNCE_CYCLES must be in 2..65535");
  end

`ifdef BOUNCE_GEN_RANDOM_EN
  localparam int unsigned GW = $clog2(GLITCH_MAX);

  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Taps 16,14,13,11 mapped onto a left-shifting register
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign interval = 8'(lfsr[GW-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign interval = 8'(GLITCH_MAX - 1);
`endif

  assign change = (i_data != target);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (change) state_next = BOUNCE;
      BOUNCE:  if (!change && burst_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new transition restarts the burst; otherwise the end-of-burst settle beats a due toggle
  always_comb begin
    target_next = target;
    data_next   = o_data;
    burst_next  = burst_cnt;
    hold_next   = hold_cnt;
    if (change) begin
      target_next = i_data;
      data_next   = i_data;
      burst_next  = 16'(BOUNCE_CYCLES - 1);
      hold_next   = interval;
    end else if (state == BOUNCE) begin
      if (burst_cnt == '0) begin
        data_next = target;
      end else begin
        burst_next = burst_cnt - 16'd1;
        if (hold_cnt == '0) begin
          data_next = ~o_data;
          hold_next = interval;
        end else begin
          hold_next = hold_cnt - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      target    <= 1'b0;
      o_data    <= 1'b0;
      o_busy    <= 1'b0;
      burst_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      target    <= target_next;
      o_data    <= data_next;
      o_busy    <= (state_next == BOUNCE);
      burst_cnt <= burst_next;
      hold_cnt  <= hold_next;
    end
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator: fixed-point vectors, corner sequences and a random run
// against a time-since-transition reference model.
module tb_bounce_generator;

  localparam int unsigned BC = 64;
  localparam int unsigned G  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles elapsed since the last accepted transition, and the settled level
  int   k   = BC;
  logic tgt = 1'b0;
  int   run = 0;
  int   tog = 0;
  logic prev_o = 1'b0;

  typedef struct {
    int   off;
    logic o;
    logic b;
  } vec_t;
  vec_t tbl[9];

  bounce_generator #(
    .BOUNCE_CYCLES(BC),
    .GLITCH_MAX   (G),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_data(din),
    .o_data(dout),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic exp_busy, exp_o;
    @(posedge clk);
    if (rst) begin
      tgt = 1'b0;
      k   = BC;
    end else if (din != tgt) begin
      tgt = din;
      k   = 0;
    end else if (k < BC) begin
      k++;
    end
    #1;
    exp_busy = (k < BC);
    exp_o    = exp_busy ? (tgt ^ ((k / G) % 2 == 1)) : tgt;
    check("model_busy", {31'd0, busy}, {31'd0, exp_busy});
`ifdef BOUNCE_GEN_RANDOM_EN
    if (!exp_busy || k == 0) check("model_data", {31'd0, dout}, {31'd0, tgt});
`else
    check("model_data", {31'd0, dout}, {31'd0, exp_o});
`endif
    if (exp_busy && dout !== tgt) run++;
    else run = 0;
    if (run > 0) check("glitch_len_ok", {31'd0, run <= G}, 32'd1);
    if (dout !== prev_o) tog++;
    prev_o = dout;
  endtask

  initial begin
    int gap;
    tbl[0] = '{0, 1'b1, 1'b1};
    tbl[1] = '{3, 1'b1, 1'b1};
    tbl[2] = '{4, 1'b0, 1'b1};
    tbl[3] = '{7, 1'b0, 1'b1};
    tbl[4] = '{8, 1'b1, 1'b1};
    tbl[5] = '{59, 1'b1, 1'b1};
    tbl[6] = '{60, 1'b0, 1'b1};
    tbl[7] = '{63, 1'b0, 1'b1};
    tbl[8] = '{64, 1'b1, 1'b0};

    rst = 1'b1; din = 1'b0;
    repeat (3) tick();
    check("reset_data", {31'd0, dout}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // Rising transition: timing of first edge, toggles and settle
    din = 1'b1;
    tick();
`ifndef BOUNCE_GEN_RANDOM_EN
    for (int i = 0; i < 9; i++) begin
      while (k < tbl[i].off) tick();
      check($sformatf("vec%0d_data", i), {31'd0, dout}, {31'd0, tbl[i].o});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
    end
`else
    while (k < BC) tick();
`endif
    repeat (3) tick();

    // Falling burst: 15 glitch toggles before the settle edge
    din = 1'b0;
    tick();
    tog = 0;
    repeat (BC - 1) tick();
`ifndef BOUNCE_GEN_RANDOM_EN
    check("toggle_count", tog, 32'd15);
`endif
    check("pre_settle_busy", {31'd0, busy}, 32'd1);
    tick();
    check("settle_data0", {31'd0, dout}, 32'd0);
    check("settle_busy0", {31'd0, busy}, 32'd0);

    // Reset mid-burst aborts, and i_data=1 at release starts a fresh burst
    din = 1'b1;
    tick();
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check("rst_abort_data", {31'd0, dout}, 32'd0);
    check("rst_abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_restart_data", {31'd0, dout}, 32'd1);
    check("rst_restart_busy", {31'd0, busy}, 32'd1);
    repeat (BC - 1) tick();
    check("rst_late_busy", {31'd0, busy}, 32'd1);
    tick();
    check("rst_settle_data", {31'd0, dout}, 32'd1);
    check("rst_settle_busy", {31'd0, busy}, 32'd0);

    // Transition reversed mid-burst restarts toward the new target
    din = 1'b0;
    tick();
    repeat (9) tick();
    din = 1'b1;
    tick();
    check("restart_data", {31'd0, dout}, 32'd1);
    check("restart_busy", {31'd0, busy}, 32'd1);
    repeat (BC - 1) tick();
    check("restart_late_busy", {31'd0, busy}, 32'd1);
    tick();
    check("restart_settle_data", {31'd0, dout}, 32'd1);
    check("restart_settle_busy", {31'd0, busy}, 32'd0);

    // Quiet input after reset produces nothing
    rst = 1'b1; din = 1'b0;
    tick();
    rst = 1'b0;
    tog = 0;
    repeat (500) tick();
    check("quiet_toggles", tog, 32'd0);
    check("quiet_busy", {31'd0, busy}, 32'd0);

    // Random transitions with occasional reset pulses
    gap = 5;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (gap == 0) begin
        din = ~din;
        gap = $urandom_range(1, 160);
      end else begin
        gap--;
      end
      tick();
    end
    rst = 1'b0;
    repeat (BC + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
